shift_seq_ctrl: RTL and testbench
=================================

// Module: shift_seq_ctrl
// PURPOSE
//   Multi-cycle sequencer for the 32-bit shift datapath (shift_register) in the NPC EXU.
//   Accepts one shift op (SLL/SRL/SRA) per valid/ready handshake.
//   Splits shamt into passes of at most MAX_STEP bits and drives the external shifter
//   one pass per cycle, feeding sh_q back into an accumulator.
//   Returns the final result on a valid/ready output handshake.
//   Keeps the shifter's per-cycle shift depth bounded for timing.
// PARAMETERS
//   MAX_STEP  8  max shift amount issued to the shifter per pass; legal range 1..31
// PORTS
//   clk          in   1   clock, rising edge
//   rst          in   1   reset, asynchronous, active-high
//   in_valid     in   1   op request
//   in_ready     out  1   sequencer can accept an op (state IDLE)
//   in_data      in   32  operand
//   in_shamt     in   5   total shift amount
//   in_l_or_r    in   1   1 = left, 0 = right
//   in_a_or_l    in   1   1 = arithmetic, 0 = logical (right shifts only)
//   flush        in   1   synchronous abort of the op in flight
//   sh_data      out  32  to shifter: current accumulator
//   sh_shamt     out  5   to shifter: this pass's amount
//   sh_l_or_r    out  1   to shifter: latched direction
//   sh_a_or_l    out  1   to shifter: latched arith/logic select
//   sh_q         in   32  from shifter: combinational result of this pass
//   out_valid    out  1   result available
//   out_ready    in   1   consumer accepts result
//   out_q        out  32  final result (the accumulator)
//   busy         out  1   state != IDLE
// BEHAVIOUR
//   States:
//     IDLE  in_ready=1
//     RUN   one shifter pass per cycle
//     DONE  out_valid=1
//   Reset (async, any state):
//     state=IDLE; acc=0; rem=0; latched dir/mode=0.
//     Outputs: in_ready=1, out_valid=0, busy=0, out_q=0, sh_*=0.
//   Accept: in_valid && in_ready at an edge.
//     Latch acc=in_data, rem=in_shamt, dir=in_l_or_r, mode=in_a_or_l.
//     Next state is RUN if in_shamt!=0, else DONE (result = in_data).
//   RUN, combinational outputs:
//     sh_data  = acc
//     sh_shamt = min(rem, MAX_STEP)
//     sh_l_or_r / sh_a_or_l = latched dir / mode
//   RUN, each edge:
//     acc <= sh_q; rem <= rem - sh_shamt.
//     When rem - sh_shamt == 0, next state is DONE.
//   Pass count: ceil(in_shamt / MAX_STEP).
//     out_valid rises exactly that many edges after the accept edge
//     (0 extra edges for shamt=0).
//   Outside RUN, sh_shamt=0 and sh_data=acc. The shifter output is ignored.
//   DONE:
//     out_valid=1 and out_q=acc, both held stable until out_ready.
//     Edge with out_ready=1 moves to IDLE.
//     No new op is accepted in the same cycle. in_ready stays 0 until IDLE.
//   flush=1 at an edge in RUN or DONE: state moves to IDLE and no output is produced.
//     flush has priority over out_ready and over pass completion.
//     flush in IDLE has no effect; an in_valid in that cycle is NOT accepted.
//   Input fields are sampled only at accept.
//     Changes while busy are ignored.
//   Widths:
//     rem is 5 bits and never underflows (sh_shamt <= rem).
//     Results equal the single-step shift because the chained passes compose
//     (SRA sign fill is preserved pass to pass).
//   rst asserted mid-RUN: immediate return to reset values.
//     The first edge after deassert behaves as IDLE.
// TESTING
//   1. SLL: data=0x0000_0001, shamt=20, MAX_STEP=8.
//      -> passes 8,8,4; out_valid 3 edges after accept; out_q=0x0010_0000.
//   2. SRA: data=0x8000_0000, shamt=31.
//      -> 4 passes (8,8,8,7); out_q=0xFFFF_FFFF.
//      SRL with the same operand -> out_q=0x0000_0001.
//   3. shamt=0, data=0xDEAD_BEEF.
//      -> DONE one edge after accept; out_q=0xDEAD_BEEF; sh_shamt never nonzero.
//   4. Backpressure: out_ready=0 for 5 cycles in DONE.
//      -> out_valid and out_q stable, in_ready=0; IDLE on the edge where out_ready=1.
//   5. flush during 2nd RUN pass of shamt=24.
//      -> IDLE next edge, no out_valid; a following op
//         (0x0000_00F0, SRL, shamt=4) yields 0x0000_000F.
//   6. Async rst pulse mid-RUN.
//      -> all outputs at reset values immediately; back-to-back ops after release
//         give correct results.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle sequencer for the 32-bit shift datapath: breaks one shift op into
// passes of at most MAX_STEP bits, chaining the external shifter's result through an accumulator.
module shift_seq_ctrl #(
  parameter int MAX_STEP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [4:0]  in_shamt,
  input  logic        in_l_or_r,
  input  logic        in_a_or_l,
  input  logic        flush,
  output logic [31:0] sh_data,
  output logic [4:0]  sh_shamt,
  output logic        sh_l_or_r,
  output logic        sh_a_or_l,
  input  logic [31:0] sh_q,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_q,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] STEP = 5'(MAX_STEP);

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  rem_q, rem_d;
  logic        dir_q, dir_d;
  logic        mode_q, mode_d;
  logic [4:0]  pass_amt;

  assign pass_amt = (rem_q < STEP) ? rem_q : STEP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
    end
  end

  // flush wins over both pass completion and the output handshake
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          acc_d   = in_data;
          rem_d   = in_shamt;
          dir_d   = in_l_or_r;
          mode_d  = in_a_or_l;
          state_d = (in_shamt != 5'd0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = sh_q;
          rem_d = rem_q - pass_amt;
          if (rem_q == pass_amt) state_d = DONE;
        end
      end
      DONE: begin
        if (flush || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_q     = acc_q;
  assign sh_data   = acc_q;
  assign sh_shamt  = (state_q == RUN) ? pass_amt : 5'd0;
  assign sh_l_or_r = dir_q;
  assign sh_a_or_l = mode_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed vector table, hand-written flush/reset
// sequences and randomized ops compared against a single-step shift reference.
module tb_shift_seq_ctrl;

  localparam int STEP = 8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic        in_l_or_r;
  logic        in_a_or_l;
  logic        flush;
  logic [31:0] sh_data;
  logic [4:0]  sh_shamt;
  logic        sh_l_or_r;
  logic        sh_a_or_l;
  logic [31:0] sh_q;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_q;
  logic        busy;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  s;
    logic        l;
    logic        a;
    logic [31:0] q;
    int          passes;
    int          hold;
  } vec_t;

  shift_seq_ctrl #(.MAX_STEP(STEP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_l_or_r (in_l_or_r),
    .in_a_or_l (in_a_or_l),
    .flush     (flush),
    .sh_data   (sh_data),
    .sh_shamt  (sh_shamt),
    .sh_l_or_r (sh_l_or_r),
    .sh_a_or_l (sh_a_or_l),
    .sh_q      (sh_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .busy      (busy)
  );

  // Stand-in for the external combinational shifter
  assign sh_q = sh_l_or_r ? (sh_data << sh_shamt)
              : (sh_a_or_l ? 32'($signed(sh_data) >>> sh_shamt) : (sh_data >> sh_shamt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int amt,
                                            input logic l, input logic a);
    logic signed [31:0] sd;
    sd = d;
    if (l) return d << amt;
    if (a) return 32'(sd >>> amt);
    return d >> amt;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".in_ready"},  32'(in_ready),  32'd1);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".busy"},      32'(busy),      32'd0);
    check({tag, ".out_q"},     out_q,          32'd0);
    check({tag, ".sh_data"},   sh_data,        32'd0);
    check({tag, ".sh_shamt"},  32'(sh_shamt),  32'd0);
    check({tag, ".sh_l_or_r"}, 32'(sh_l_or_r), 32'd0);
    check({tag, ".sh_a_or_l"}, 32'(sh_a_or_l), 32'd0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
  task automatic run_op(input vec_t v, input string tag);
    int rem;
    int done_amt;
    int amt;
    int edges;
    check({tag, ".in_ready_pre"}, 32'(in_ready), 32'd1);
    in_data   = v.d;
    in_shamt  = v.s;
    in_l_or_r = v.l;
    in_a_or_l = v.a;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    in_data   = $urandom;
    in_shamt  = 5'($urandom);
    in_l_or_r = 1'($urandom);
    in_a_or_l = 1'($urandom);
    rem = int'(v.s);
    done_amt = 0;
    edges = 0;
    while (!out_valid && edges < 40) begin
      amt = (rem < STEP) ? rem : STEP;
      check({tag, ".sh_shamt"},  32'(sh_shamt),  32'(amt));
      check({tag, ".sh_data"},   sh_data,        ref_shift(v.d, done_amt, v.l, v.a));
      check({tag, ".sh_l_or_r"}, 32'(sh_l_or_r), 32'(v.l));
      check({tag, ".sh_a_or_l"}, 32'(sh_a_or_l), 32'(v.a));
      rem -= amt;
      done_amt += amt;
      @(negedge clk);
      edges++;
    end
    check({tag, ".latency"},       32'(edges),    32'(v.passes));
    check({tag, ".out_q"},         out_q,         v.q);
    check({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
    check({tag, ".busy_done"},     32'(busy),     32'd1);
    check({tag, ".sh_shamt_done"}, 32'(sh_shamt), 32'd0);
    out_ready = 1'b0;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".hold_q"},     out_q,          v.q);
      check({tag, ".hold_ready"}, 32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, ".idle_ready"}, 32'(in_ready),  32'd1);
    check({tag, ".idle_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".idle_busy"},  32'(busy),      32'd0);
  endtask

  task automatic start_op(input logic [31:0] d, input logic [4:0] s,
                          input logic l, input logic a);
    in_data   = d;
    in_shamt  = s;
    in_l_or_r = l;
    in_a_or_l = a;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  vec_t vecs[8];
  vec_t rv;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_shamt = '0;
    in_l_or_r = 1'b0;
    in_a_or_l = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;

    vecs[0] = '{32'h0000_0001, 5'd20, 1'b1, 1'b0, 32'h0010_0000, 3, 0};
    vecs[1] = '{32'h8000_0000, 5'd31, 1'b0, 1'b1, 32'hFFFF_FFFF, 4, 0};
    vecs[2] = '{32'h8000_0000, 5'd31, 1'b0, 1'b0, 32'h0000_0001, 4, 1};
    vecs[3] = '{32'hDEAD_BEEF, 5'd0,  1'b1, 1'b0, 32'hDEAD_BEEF, 0, 0};
    vecs[4] = '{32'h1234_5678, 5'd8,  1'b1, 1'b0, 32'h3456_7800, 1, 5};
    vecs[5] = '{32'hF000_0000, 5'd9,  1'b0, 1'b1, 32'hFFF8_0000, 2, 0};
    vecs[6] = '{32'hA5A5_A5A5, 5'd16, 1'b0, 1'b0, 32'h0000_A5A5, 2, 2};
    vecs[7] = '{32'h0000_000F, 5'd1,  1'b1, 1'b0, 32'h0000_001E, 1, 0};

    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // flush during the second pass of a 24-bit shift
    start_op(32'h0000_0001, 5'd24, 1'b1, 1'b0);
    @(negedge clk);
    flush = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b0;
    check("flush_run.in_ready",  32'(in_ready),  32'd1);
    check("flush_run.out_valid", 32'(out_valid), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("flush_run.no_valid", 32'(out_valid), 32'd0);
    end
    run_op('{32'h0000_00F0, 5'd4, 1'b0, 1'b0, 32'h0000_000F, 1, 0}, "after_flush");

    // flush beats completion of the final pass
    start_op(32'h0000_0003, 5'd5, 1'b1, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_last.out_valid", 32'(out_valid), 32'd0);
    check("flush_last.in_ready",  32'(in_ready),  32'd1);

    // flush in DONE with backpressure, then flush in IDLE blocks an accept
    start_op(32'h0000_0003, 5'd0, 1'b1, 1'b0);
    check("flush_done.pre_valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("flush_done.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_idle.busy",     32'(busy),      32'd0);
    check("flush_idle.in_ready", 32'(in_ready),  32'd1);

    // asynchronous reset pulse mid-RUN
    start_op(32'h8000_0000, 5'd31, 1'b0, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst.in_ready", 32'(in_ready), 32'd1);
    run_op('{32'h0000_00F0, 5'd4, 1'b0, 1'b0, 32'h0000_000F, 1, 0}, "b2b0");
    run_op('{32'hC000_0001, 5'd17, 1'b0, 1'b1, 32'hFFFF_E000, 3, 0}, "b2b1");

    for (int i = 0; i < 60; i++) begin
      rv.d = $urandom;
      rv.s = 5'($urandom_range(0, 31));
      rv.l = 1'($urandom_range(0, 1));
      rv.a = 1'($urandom_range(0, 1));
      rv.q = ref_shift(rv.d, int'(rv.s), rv.l, rv.a);
      rv.passes = (int'(rv.s) + STEP - 1) / STEP;
      rv.hold = $urandom_range(0, 3);
      run_op(rv, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
